// File: rtl/multi_we_dp_bram_fwd.sv
// Simple-dual-port byte-write RAM with write-first collision forwarding,
// 1- or 2-cycle read latency and a zero-fill clear sequencer.
module multi_we_dp_bram_fwd #(
    parameter int    NUM_COL      = 4,
    parameter int    COL_WIDTH    = 8,
    parameter int    ADDR_WIDTH   = 10,
    localparam int   DATA_WIDTH   = NUM_COL * COL_WIDTH,
    parameter int    READ_LATENCY = 1,
    parameter string RAM_TYPE     = "block"
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    output logic                      busy,
    input  logic                      re,
    input  logic [ADDR_WIDTH-1:0]     rad,
    input  logic [DATA_WIDTH/8-1:0]   we,
    input  logic [ADDR_WIDTH-1:0]     wad,
    input  logic [DATA_WIDTH-1:0]     wdat,
    output logic [DATA_WIDTH-1:0]     rdat,
    output logic                      rvalid
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("multi_we_dp_bram_fwd: READ_LATENCY must be 1 or 2");
        end
        if (COL_WIDTH % 8 != 0) begin : g_bad_col_width
            $error("multi_we_dp_bram_fwd: COL_WIDTH must be a multiple of 8");
        end
    endgenerate

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic                    run_cycle;

    (* ram_style = RAM_TYPE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0]   rd_next;
    logic [DATA_WIDTH-1:0]   rd1;
    logic                    v1;

    // User traffic is only honoured once the sequencer has released the array.
    assign run_cycle = (state == RUN) && !rst;

    // Terminal detection on the all-ones address avoids wrap aliasing of cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (cnt == {ADDR_WIDTH{1'b1}}) begin
                        state <= RUN;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (clr) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (run_cycle) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (we[k]) begin
                    mem[wad][8*k +: 8] <= wdat[8*k +: 8];
                end
            end
        end
    end

    // Same-address write in the read cycle wins per byte (write-first).
    always_comb begin
        rd_next = mem[rad];
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (we[k] && (wad == rad)) begin
                rd_next[8*k +: 8] = wdat[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            rd1 <= '0;
        end else begin
            v1 <= run_cycle && re;
            if (run_cycle && re) begin
                rd1 <= rd_next;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] rd2;
            logic                  v2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v2  <= 1'b0;
                    rd2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        rd2 <= rd1;
                    end
                end
            end

            assign rdat   = rd2;
            assign rvalid = v2;
        end else begin : g_lat1
            assign rdat   = rd1;
            assign rvalid = v1;
        end
    endgenerate

endmodule

// File: tb/tb_multi_we_dp_bram_fwd.sv
// Directed bench: one 1-cycle and one 2-cycle instance share all inputs,
// each scenario task checks its own hand-computed expectations.
module tb_multi_we_dp_bram_fwd;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          clr;
    logic          re;
    logic [AW-1:0] rad;
    logic [3:0]    we;
    logic [AW-1:0] wad;
    logic [DW-1:0] wdat;

    logic          busy1, rvalid1;
    logic [DW-1:0] rdat1;
    logic          busy2, rvalid2;
    logic [DW-1:0] rdat2;

    int vectors;
    int miscompares;

    multi_we_dp_bram_fwd #(
        .NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(AW), .READ_LATENCY(1), .RAM_TYPE("block")
    ) u_lat1 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy1),
        .re(re), .rad(rad), .we(we), .wad(wad), .wdat(wdat),
        .rdat(rdat1), .rvalid(rvalid1)
    );

    multi_we_dp_bram_fwd #(
        .NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(AW), .READ_LATENCY(2), .RAM_TYPE("block")
    ) u_lat2 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy2),
        .re(re), .rad(rad), .we(we), .wad(wad), .wdat(wdat),
        .rdat(rdat2), .rvalid(rvalid2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1;
        tick;
        tick;
        vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL reset_busy1 got %b want 1", busy1); end
        vectors++; if (busy2 !== 1'b1) begin miscompares++; $display("FAIL reset_busy2 got %b want 1", busy2); end
        vectors++; if (rvalid1 !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid1 got %b want 0", rvalid1); end
        vectors++; if (rvalid2 !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid2 got %b want 0", rvalid2); end
        vectors++; if (rdat1 !== 32'h0) begin miscompares++; $display("FAIL reset_rdat1 got %h want 0", rdat1); end
        vectors++; if (rdat2 !== 32'h0) begin miscompares++; $display("FAIL reset_rdat2 got %h want 0", rdat2); end
        rst = 1'b0;
        n = 0;
        while (busy1 === 1'b1 && n < 40) begin
            n++;
            tick;
        end
        vectors++; if (n !== 16) begin miscompares++; $display("FAIL reset_busy_len got %0d want 16", n); end
    endtask

    task automatic test_clear_contents;
        for (int a = 0; a < 16; a++) begin
            re  = 1'b1;
            rad = AW'(a);
            tick;
            vectors++; if (rvalid1 !== 1'b1) begin miscompares++; $display("FAIL clear_rvalid a=%0d got %b want 1", a, rvalid1); end
            vectors++; if (rdat1 !== 32'h0) begin miscompares++; $display("FAIL clear_rdat a=%0d got %h want 0", a, rdat1); end
        end
        re = 1'b0;
        tick;
        vectors++; if (rvalid1 !== 1'b0) begin miscompares++; $display("FAIL clear_rvalid_fall got %b want 0", rvalid1); end
    endtask

    task automatic test_byte_write;
        we = 4'hF; wad = 4'd3; wdat = 32'h11223344;
        tick;
        we = 4'b0101; wdat = 32'hAABBCCDD;
        tick;
        we = 4'h0; re = 1'b1; rad = 4'd3;
        tick;
        vectors++; if (rdat1 !== 32'h11BB33DD) begin miscompares++; $display("FAIL bytewr_rdat1 got %h want 11bb33dd", rdat1); end
        vectors++; if (rvalid1 !== 1'b1) begin miscompares++; $display("FAIL bytewr_rvalid1 got %b want 1", rvalid1); end
        vectors++; if (rvalid2 !== 1'b0) begin miscompares++; $display("FAIL bytewr_rvalid2_early got %b want 0", rvalid2); end
        re = 1'b0;
        tick;
        vectors++; if (rvalid1 !== 1'b0) begin miscompares++; $display("FAIL bytewr_rvalid1_fall got %b want 0", rvalid1); end
        vectors++; if (rdat1 !== 32'h11BB33DD) begin miscompares++; $display("FAIL bytewr_rdat1_hold got %h want 11bb33dd", rdat1); end
        vectors++; if (rvalid2 !== 1'b1) begin miscompares++; $display("FAIL bytewr_rvalid2 got %b want 1", rvalid2); end
        vectors++; if (rdat2 !== 32'h11BB33DD) begin miscompares++; $display("FAIL bytewr_rdat2 got %h want 11bb33dd", rdat2); end
        tick;
        vectors++; if (rvalid2 !== 1'b0) begin miscompares++; $display("FAIL bytewr_rvalid2_fall got %b want 0", rvalid2); end
        vectors++; if (rdat2 !== 32'h11BB33DD) begin miscompares++; $display("FAIL bytewr_rdat2_hold got %h want 11bb33dd", rdat2); end
    endtask

    task automatic test_collision;
        we = 4'hF; wad = 4'd7; wdat = 32'h01020304;
        tick;
        re = 1'b1; rad = 4'd7; we = 4'b1100; wad = 4'd7; wdat = 32'hFFEEDDCC;
        tick;
        vectors++; if (rdat1 !== 32'hFFEE0304) begin miscompares++; $display("FAIL coll_rdat1 got %h want ffee0304", rdat1); end
        we = 4'h0;
        tick;
        vectors++; if (rdat1 !== 32'hFFEE0304) begin miscompares++; $display("FAIL coll_reread_rdat1 got %h want ffee0304", rdat1); end
        vectors++; if (rdat2 !== 32'hFFEE0304) begin miscompares++; $display("FAIL coll_rdat2 got %h want ffee0304", rdat2); end
        re = 1'b0;
        tick;
        vectors++; if (rdat2 !== 32'hFFEE0304) begin miscompares++; $display("FAIL coll_reread_rdat2 got %h want ffee0304", rdat2); end
        re = 1'b1; rad = 4'd7;
        tick;
        re = 1'b0; we = 4'hF; wad = 4'd7; wdat = 32'h12345678;
        tick;
        vectors++; if (rdat2 !== 32'hFFEE0304) begin miscompares++; $display("FAIL nofwd_late_rdat2 got %h want ffee0304", rdat2); end
        we = 4'h0; re = 1'b1; rad = 4'd7;
        tick;
        vectors++; if (rdat1 !== 32'h12345678) begin miscompares++; $display("FAIL late_write_rdat1 got %h want 12345678", rdat1); end
        re = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        tick;
        we = 4'hF; wad = 4'd1; wdat = 32'h00001111;
        tick;
        wad = 4'd2; wdat = 32'h22220000;
        tick;
        wad = 4'd3; wdat = 32'h33333333;
        tick;
        we = 4'h0; re = 1'b1; rad = 4'd1;
        tick;
        vectors++; if (rvalid2 !== 1'b0) begin miscompares++; $display("FAIL b2b_rvalid2_c1 got %b want 0", rvalid2); end
        vectors++; if (rdat1 !== 32'h00001111) begin miscompares++; $display("FAIL b2b_rdat1 got %h want 00001111", rdat1); end
        rad = 4'd2;
        tick;
        vectors++; if (rvalid2 !== 1'b1) begin miscompares++; $display("FAIL b2b_rvalid2_c2 got %b want 1", rvalid2); end
        vectors++; if (rdat2 !== 32'h00001111) begin miscompares++; $display("FAIL b2b_rdat2_c2 got %h want 00001111", rdat2); end
        rad = 4'd3;
        tick;
        vectors++; if (rvalid2 !== 1'b1) begin miscompares++; $display("FAIL b2b_rvalid2_c3 got %b want 1", rvalid2); end
        vectors++; if (rdat2 !== 32'h22220000) begin miscompares++; $display("FAIL b2b_rdat2_c3 got %h want 22220000", rdat2); end
        re = 1'b0;
        tick;
        vectors++; if (rvalid2 !== 1'b1) begin miscompares++; $display("FAIL b2b_rvalid2_c4 got %b want 1", rvalid2); end
        vectors++; if (rdat2 !== 32'h33333333) begin miscompares++; $display("FAIL b2b_rdat2_c4 got %h want 33333333", rdat2); end
        tick;
        vectors++; if (rvalid2 !== 1'b0) begin miscompares++; $display("FAIL b2b_rvalid2_c5 got %b want 0", rvalid2); end
    endtask

    task automatic test_clr;
        int  n;
        int  bad;
        bit  done;
        re = 1'b1; rad = 4'd1; clr = 1'b1;
        tick;
        vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL clr_busy_rise got %b want 1", busy1); end
        vectors++; if (rvalid1 !== 1'b1) begin miscompares++; $display("FAIL clr_cycle_rvalid got %b want 1", rvalid1); end
        vectors++; if (rdat1 !== 32'h00001111) begin miscompares++; $display("FAIL clr_cycle_rdat got %h want 00001111", rdat1); end
        clr = 1'b0; rad = 4'd2;
        n = 1; bad = 0; done = 1'b0;
        while (!done && n < 40) begin
            clr = (n == 8);
            tick;
            if (rvalid1 !== 1'b0) bad++;
            if (busy1 === 1'b1) n++;
            else done = 1'b1;
        end
        clr = 1'b0;
        vectors++; if (n !== 16) begin miscompares++; $display("FAIL clr_busy_len got %0d want 16", n); end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL clr_busy_rvalid got %0d cycles want 0", bad); end
        tick;
        vectors++; if (rdat1 !== 32'h0) begin miscompares++; $display("FAIL clr_zero_a2 got %h want 0", rdat1); end
        rad = 4'd3;
        tick;
        vectors++; if (rdat1 !== 32'h0) begin miscompares++; $display("FAIL clr_zero_a3 got %h want 0", rdat1); end
        rad = 4'd7;
        tick;
        vectors++; if (rdat1 !== 32'h0) begin miscompares++; $display("FAIL clr_zero_a7 got %h want 0", rdat1); end
        vectors++; if (rvalid1 !== 1'b1) begin miscompares++; $display("FAIL clr_after_rvalid got %b want 1", rvalid1); end
        re = 1'b0;
        tick;
    endtask

    task automatic test_rst_mid_clear;
        int n;
        re = 1'b1; rad = 4'd3; clr = 1'b1;
        tick;
        re = 1'b0; clr = 1'b0; rst = 1'b1;
        tick;
        vectors++; if (rvalid2 !== 1'b0) begin miscompares++; $display("FAIL rstflush_rvalid2 got %b want 0", rvalid2); end
        vectors++; if (rdat2 !== 32'h0) begin miscompares++; $display("FAIL rstflush_rdat2 got %h want 0", rdat2); end
        vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL rstflush_busy got %b want 1", busy1); end
        rst = 1'b0;
        repeat (5) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        wad = 4'd2; wdat = 32'hDEADBEEF;
        n = 0;
        while (busy1 === 1'b1 && n < 40) begin
            n++;
            we = (n == 12) ? 4'hF : 4'h0;
            tick;
        end
        we = 4'h0;
        vectors++; if (n !== 16) begin miscompares++; $display("FAIL rstmid_busy_len got %0d want 16", n); end
        re = 1'b1; rad = 4'd2;
        tick;
        vectors++; if (rvalid1 !== 1'b1) begin miscompares++; $display("FAIL rstmid_rvalid got %b want 1", rvalid1); end
        vectors++; if (rdat1 !== 32'h0) begin miscompares++; $display("FAIL rstmid_dropped_write got %h want 0", rdat1); end
        re = 1'b0;
        tick;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; clr = 1'b0; re = 1'b0; rad = '0;
        we = '0; wad = '0; wdat = '0;
        test_reset;
        test_clear_contents;
        test_byte_write;
        test_collision;
        test_back_to_back;
        test_clr;
        test_rst_mid_clear;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_we_dp_bram_fwd.md
Name: multi_we_dp_bram_fwd

Overview:
- Parametrised simple-dual-port RAM with byte write enables: one write port, one read port.
- Adds three features the existing byte-write RAMs lack: write-first forwarding on same-address read/write collisions, a selectable 1- or 2-cycle read latency, and a hardware clear sequencer that zero-fills the array after reset or on request.
- Used as the tag/data store in mruCache, where invalidation-by-clear is required.

Parameters:
- NUM_COL, 4: number of columns per word.
- COL_WIDTH, 8: column width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10: address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, NUM_COL*COL_WIDTH: word width; derived, not overridden.
- READ_LATENCY, 1: read latency; 1 or 2 only. Any other value is an elaboration error.
- RAM_TYPE, "block": ram_style attribute applied to the array.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  pulse; requests a full zero-fill of the array.
- busy  out  1  high while the clear sequencer owns the array.
- re  in  1  read enable.
- rad  in  ADDR_WIDTH  read address.
- we  in  DATA_WIDTH/8  byte write enables; bit k controls wdat[8k+:8].
- wad  in  ADDR_WIDTH  write address.
- wdat  in  DATA_WIDTH  write data.
- rdat  out  DATA_WIDTH  read data.
- rvalid  out  1  rdat carries the result of an accepted read.

Behaviour:
- Reset: one clock and one reset only; reset is synchronous and active-high.
  - rst=1 forces state CLEAR, clear counter = 0, busy=1, rvalid=0, rdat=0, and all pipeline valids = 0.
  - Array contents are not reset directly; they are zeroed by the sequencer.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle writes all-zero to address cnt, then cnt increments.
  - When cnt==2**ADDR_WIDTH-1 is written, the next state is RUN and cnt returns to 0.
  - busy=1 for exactly 2**ADDR_WIDTH cycles after rst deasserts.
  - re and we are ignored: no reads are accepted, rvalid stays 0, and user writes are dropped.
  - clr is ignored (the sequencer does not restart).
- RUN:
  - busy=0.
  - clr=1 sampled in RUN moves to CLEAR next cycle with cnt=0. Reads accepted in that same cycle still complete normally.
  - re and we in the clr cycle are still honoured.
- Write: in RUN, each byte k with we[k]=1 updates mem[wad][8k+:8] at the clock edge. Bytes with we[k]=0 are unchanged.
- Read, READ_LATENCY=1:
  - re=1 at edge N gives rdat and rvalid=1 after edge N.
  - rvalid falls the next cycle if re=0.
  - rdat holds its last value when no read is accepted.
- Read, READ_LATENCY=2:
  - Adds an output register stage; rdat and rvalid appear one cycle later.
  - Stage 2 loads only when stage 1 is valid, otherwise rdat holds.
  - Back-to-back reads are fully pipelined: one result per cycle.
- Collision (RUN, re=1, we!=0, rad==wad, same cycle): returned data is write-first per byte.
  - Bytes with we[k]=1 return wdat byte k.
  - Bytes with we[k]=0 return the prior memory byte.
- No forwarding for writes landing after the read cycle. Data reflects memory as of the read edge (plus the same-cycle write).
- Reset mid-CLEAR restarts the clear from address 0.
- Reset mid-read flushes pipeline valids; no rvalid is produced.
- Width rules: address compare is full ADDR_WIDTH; the clear counter is ADDR_WIDTH+1 bits or uses explicit terminal detection, with no wrap aliasing.

Test Plan:
- ADDR_WIDTH=4, rst pulse, then idle -> busy=1 for exactly 16 cycles. Afterwards a read of each of addresses 0..15 returns 0x00000000 with rvalid one cycle after re (READ_LATENCY=1).
- Write 0x11223344 to addr 3 with we=4'hF, then write 0xAABBCCDD to addr 3 with we=4'b0101, then read addr 3 -> rdat=0x11BB33DD.
- Addr 7 holds 0x01020304; same cycle drive re=1, rad=7, we=4'b1100, wad=7, wdat=0xFFEEDDCC -> rdat=0xFFEE0304. A read of addr 7 on the following cycle returns 0xFFEE0304.
- READ_LATENCY=2, reads of addrs 1,2,3 on consecutive cycles -> rvalid high for 3 consecutive cycles starting 2 cycles after the first re, with data in order.
- In RUN, pulse clr for 1 cycle -> busy rises the next cycle and stays high for 16 cycles. re asserted during busy yields no rvalid. Afterwards previously written addresses read 0.
- rst asserted 5 cycles into a clear, then released -> busy stays high for 16 full cycles from release. A write attempted during busy is absent from memory afterwards.
